light_scheduler: RTL and testbench

Sequencing controller for the lights selector datapath. It drives the selector's `sel` and `button` inputs to run an automatic light show: a white phase, then a fixed number of RGB colour steps, each advanced by a one-cycle `button` pulse. It also grants the selector to a manual requester through a request/grant handshake. It sits between the board controls and the selector, and is the only driver of the selector's `sel` and `button`.

---
 rtl/light_scheduler.sv | 159 +++++++++++++++
 tb/tb_light_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_scheduler.sv
// rtl/light_scheduler.sv - light show sequencer and manual arbiter driving the lights selector
// Optional feature: define LIGHT_SCHED_REPEAT_EN to loop the show instead of stopping after the last step.
module light_scheduler #(
   parameter int WHITE_CYCLES  = 8,
   parameter int COLOUR_CYCLES = 8,
   parameter int STEPS         = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       manual_req,
   input  logic       manual_sel,
   input  logic       manual_btn,
   output logic       sel,
   output logic       button,
   output logic       manual_gnt,
   output logic       busy,
   output logic       done,
   output logic [7:0] step
);

   typedef enum logic [1:0] {
      IDLE,
      WHITE,
      COLOUR,
      MANUAL
   } state_t;

   localparam logic [15:0] WHITE_LOAD  = 16'(WHITE_CYCLES - 1);
   localparam logic [15:0] COLOUR_LOAD = 16'(COLOUR_CYCLES - 1);
   localparam logic [7:0]  LAST_STEP   = 8'(STEPS - 1);

   state_t      state_q;
   state_t      state_d;
   logic [15:0] timer_q;
   logic [15:0] timer_d;
   logic [7:0]  step_d;
   logic        sel_d;
   logic        button_d;
   logic        gnt_d;
   logic        busy_d;
   logic        done_d;
   logic        btn_hist_q;

   // Next state, timer and step; outputs are derived from the next state so they can be registered.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      step_d   = step;
      sel_d    = 1'b0;
      button_d = 1'b0;
      gnt_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (manual_req) begin
               state_d = MANUAL;
            end else if (start && !stop) begin
               state_d = WHITE;
               timer_d = WHITE_LOAD;
            end
         end
         WHITE: begin
            if (manual_req) begin
               state_d = MANUAL;
            end else if (stop) begin
               state_d = IDLE;
            end else if (timer_q == 16'd0) begin
               state_d = COLOUR;
               step_d  = 8'd0;
               timer_d = COLOUR_LOAD;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         COLOUR: begin
            if (manual_req) begin
               state_d = MANUAL;
            end else if (stop) begin
               state_d = IDLE;
            end else if (timer_q == 16'd0) begin
               if (step < LAST_STEP) begin
                  step_d   = step + 8'd1;
                  timer_d  = COLOUR_LOAD;
                  button_d = 1'b1;
               end else begin
`ifdef LIGHT_SCHED_REPEAT_EN
                  state_d = WHITE;
                  timer_d = WHITE_LOAD;
                  step_d  = 8'd0;
`else
                  state_d = IDLE;
`endif
                  done_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         MANUAL: begin
            // Pulses only while already granted, so a grant edge never carries a button pulse.
            if (!manual_req) begin
               state_d = IDLE;
            end else begin
               button_d = manual_btn && !btn_hist_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d != COLOUR) begin
         step_d = 8'd0;
      end
      if (state_d == IDLE || state_d == MANUAL) begin
         timer_d = 16'd0;
      end
      sel_d  = (state_d == COLOUR) || ((state_d == MANUAL) && manual_sel);
      gnt_d  = (state_d == MANUAL);
      busy_d = (state_d == WHITE) || (state_d == COLOUR);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         timer_q    <= 16'd0;
         step       <= 8'd0;
         sel        <= 1'b0;
         button     <= 1'b0;
         manual_gnt <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         step       <= step_d;
         sel        <= sel_d;
         button     <= button_d;
         manual_gnt <= gnt_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   // Manual button history, tracked in every state so a held button gives no pulse on grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_hist_q <= 1'b0;
      end else begin
         btn_hist_q <= manual_btn;
      end
   end

endmodule

// File: tb/tb_light_scheduler.sv
// tb/tb_light_scheduler.sv - self-checking bench for light_scheduler
`timescale 1ns/1ps
module tb_light_scheduler;
   localparam int WC    = 4;
   localparam int CC    = 3;
   localparam int NS    = 3;
   localparam int TOTAL = WC + NS * CC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       manual_req = 1'b0;
   logic       manual_sel = 1'b0;
   logic       manual_btn = 1'b0;
   logic       sel;
   logic       button;
   logic       manual_gnt;
   logic       busy;
   logic       done;
   logic [7:0] step;

   int checks = 0;
   int errors = 0;

   int lit_sel[14]  = '{0,0,0,0,1,1,1,1,1,1,1,1,1,0};
   int lit_btn[14]  = '{0,0,0,0,0,0,0,1,0,0,1,0,0,0};
   int lit_step[14] = '{0,0,0,0,0,0,0,1,1,1,2,2,2,0};
   int lit_done[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1};
`ifdef LIGHT_SCHED_REPEAT_EN
   int lit_busy[14] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1};
`else
   int lit_busy[14] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0};
`endif

   light_scheduler #(
      .WHITE_CYCLES (WC),
      .COLOUR_CYCLES(CC),
      .STEPS        (NS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .manual_req(manual_req),
      .manual_sel(manual_sel),
      .manual_btn(manual_btn),
      .sel       (sel),
      .button    (button),
      .manual_gnt(manual_gnt),
      .busy      (busy),
      .done      (done),
      .step      (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode 0 idle, 1 show (m_t cycles since start), 2 manual.
   int m_mode = 0;
   int m_t    = 0;
   bit m_hist = 1'b0;
   bit m_msel = 1'b0;
   bit e_button = 1'b0;
   bit e_done   = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = 0; m_t = 0; m_hist = 1'b0; m_msel = 1'b0;
         e_button = 1'b0; e_done = 1'b0;
      end else begin
         e_button = 1'b0;
         e_done   = 1'b0;
         if (m_mode == 2) begin
            if (!manual_req) m_mode = 0;
            else begin
               e_button = manual_btn && !m_hist;
               m_msel   = manual_sel;
            end
         end else if (manual_req) begin
            m_mode = 2;
            m_msel = manual_sel;
         end else if (m_mode == 1) begin
            if (stop) m_mode = 0;
            else begin
               m_t++;
               if (m_t == TOTAL) begin
                  e_done = 1'b1;
`ifdef LIGHT_SCHED_REPEAT_EN
                  m_t = 0;
`else
                  m_mode = 0;
`endif
               end else if (m_t > WC && (m_t - WC) % CC == 0) begin
                  e_button = 1'b1;
               end
            end
         end else if (start && !stop) begin
            m_mode = 1;
            m_t    = 0;
         end
         m_hist = manual_btn;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("m_sel", sel, int'((m_mode == 1 && m_t >= WC) || (m_mode == 2 && m_msel)));
      check("m_step", step, (m_mode == 1 && m_t >= WC) ? (m_t - WC) / CC : 0);
      check("m_button", button, int'(e_button));
      check("m_done", done, int'(e_done));
      check("m_busy", busy, int'(m_mode == 1));
      check("m_gnt", manual_gnt, int'(m_mode == 2));
   end

   task automatic kick_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic full_show(input bit extra_start);
      kick_start();
      for (int c = 0; c <= TOTAL; c++) begin
         check("lit_sel", sel, lit_sel[c]);
         check("lit_button", button, lit_btn[c]);
         check("lit_step", step, lit_step[c]);
         check("lit_done", done, lit_done[c]);
         check("lit_busy", busy, lit_busy[c]);
         if (extra_start && c == 2) start = 1'b1;
         if (extra_start && c == 3) start = 1'b0;
         if (c < TOTAL) @(negedge clk);
      end
      @(negedge clk);
`ifdef LIGHT_SCHED_REPEAT_EN
      check("rep_step", step, 0);
      repeat (6) @(negedge clk);
      check("rep_button", button, 1);
      check("rep_step1", step, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("rep_stop_busy", busy, 0);
`endif
   endtask

   int pulses;

   initial begin
      #2 rst = 1'b0;
      #1;
      check("rst_sel", sel, 0);
      check("rst_button", button, 0);
      check("rst_gnt", manual_gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_step", step, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      full_show(1'b0);
      repeat (2) @(negedge clk);

      // Stop during step 1.
      kick_start();
      for (int c = 0; c <= 13; c++) begin
         if (c == 7) check("stop_button7", button, 1);
         if (c == 8) begin
            check("stop_step8", step, 1);
            stop = 1'b1;
         end
         if (c == 9) begin
            stop = 1'b0;
            check("stop_sel9", sel, 0);
            check("stop_step9", step, 0);
            check("stop_busy9", busy, 0);
         end
         if (c == 13) check("stop_done13", done, 0);
         @(negedge clk);
      end

      // Manual request preempts a running show.
      kick_start();
      repeat (5) @(negedge clk);
      manual_req = 1'b1;
      manual_sel = 1'b1;
      @(negedge clk);
      check("man_gnt6", manual_gnt, 1);
      check("man_sel6", sel, 1);
      check("man_busy6", busy, 0);
      pulses = 0;
      manual_btn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pulses += int'(button);
      end
      manual_btn = 1'b0;
      repeat (2) begin
         @(negedge clk);
         pulses += int'(button);
      end
      check("man_pulses", pulses, 1);
      manual_sel = 1'b0;
      @(negedge clk);
      check("man_sel_follow", sel, 0);
      manual_req = 1'b0;
      @(negedge clk);
      check("man_gnt_drop", manual_gnt, 0);
      check("man_sel_drop", sel, 0);

      // Held button on entry gives no pulse.
      manual_btn = 1'b1;
      @(negedge clk);
      manual_req = 1'b1;
      repeat (3) @(negedge clk);
      check("man_held_btn", button, 0);
      manual_req = 1'b0;
      manual_btn = 1'b0;
      @(negedge clk);

      // Start with stop in idle.
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("startstop_busy", busy, 0);
      @(negedge clk);

      // Second start mid-run changes nothing.
      full_show(1'b1);
      @(negedge clk);

      // Asynchronous reset during step 2.
      kick_start();
      repeat (11) @(negedge clk);
      check("pre_rst_step", step, 2);
      #2 rst = 1'b0;
      #1;
      check("arst_sel", sel, 0);
      check("arst_step", step, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      full_show(1'b0);
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
